// File: rtl/dac_output_stage.sv
// ============================================================================
// Module      : dac_output_stage
// Description : DAC output stage. Applies a soft-start/soft-stop gain ramp
//               keyed on the DAC enable to two signed sample streams, converts
//               the result to the DAC code format and also presents a single
//               interleaved bus with a channel select.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk          in   1     system clock
//   rst_n        in   1     asynchronous active-low reset
//   dac_en_i     in   1     enable (level); starts ramp up / ramp down
//   dac_ch0_i    in   DW    channel 0 sample, two's complement
//   dac_ch1_i    in   DW    channel 1 sample, two's complement
//   dac_ch0_o    out  DW    channel 0 scaled, formatted code (3-cycle latency)
//   dac_ch1_o    out  DW    channel 1 scaled, formatted code (3-cycle latency)
//   dac_data_o   out  DW    interleaved code: ch0 when dac_sel_o=0, else ch1
//   dac_sel_o    out  1     interleave select, toggles every clk
//   dac_on_o     out  1     high in state ON
//   ramp_busy_o  out  1     high in RAMP_UP / RAMP_DOWN
//   gain_o       out  GW+1  current gain, unity = 2**GW
// ============================================================================
`default_nettype none

module dac_output_stage #(
  parameter int DW         = 14,
  parameter int GW         = 8,
  parameter int RAMP_DIV   = 64,
  parameter int OFFSET_BIN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dac_en_i,
  input  logic [DW-1:0] dac_ch0_i,
  input  logic [DW-1:0] dac_ch1_i,
  output logic [DW-1:0] dac_ch0_o,
  output logic [DW-1:0] dac_ch1_o,
  output logic [DW-1:0] dac_data_o,
  output logic          dac_sel_o,
  output logic          dac_on_o,
  output logic          ramp_busy_o,
  output logic [GW:0]   gain_o
);

  localparam int            PW        = DW + GW + 2;
  localparam int            DIVW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(RAMP_DIV - 1);
  localparam logic [GW:0]   GAIN_MAX  = {1'b1, {GW{1'b0}}};
  // XOR mask applied to the two's complement result; for offset binary it
  // flips the MSB, which also makes it the midscale (zero-sample) code.
  localparam logic [DW-1:0] FMT_MASK  = (OFFSET_BIN != 0) ? {1'b1, {(DW-1){1'b0}}}
                                                           : {DW{1'b0}};

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [GW:0]     gain_q, gain_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            on_q, on_d;
  logic            busy_q, busy_d;

  // --------------------------------------------------------------------------
  // Ramp control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    div_d   = div_q;
    unique case (state_q)
      ST_OFF: begin
        gain_d = '0;
        if (dac_en_i) begin
          state_d = ST_RAMP_UP;
          div_d   = '0;
        end
      end
      ST_RAMP_UP: begin
        if (!dac_en_i) begin
          state_d = ST_RAMP_DOWN;
          div_d   = '0;
        end else if (gain_q == GAIN_MAX) begin
          // Re-entered from RAMP_DOWN while already at unity: never overshoot.
          state_d = ST_ON;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          gain_d = gain_q + 1'b1;
          div_d  = '0;
          if (gain_d == GAIN_MAX) state_d = ST_ON;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_ON: begin
        gain_d = GAIN_MAX;
        if (!dac_en_i) begin
          state_d = ST_RAMP_DOWN;
          div_d   = '0;
        end
      end
      ST_RAMP_DOWN: begin
        if (dac_en_i) begin
          state_d = ST_RAMP_UP;
          div_d   = '0;
        end else if (gain_q == '0) begin
          // Re-entered from RAMP_UP while still at zero: never underflow.
          state_d = ST_OFF;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          gain_d = gain_q - 1'b1;
          div_d  = '0;
          if (gain_d == '0) state_d = ST_OFF;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        gain_d  = '0;
        div_d   = '0;
      end
    endcase
    on_d   = (state_d == ST_ON);
    busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      gain_q  <= '0;
      div_q   <= '0;
      on_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      div_q   <= div_d;
      on_q    <= on_d;
      busy_q  <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: S1 capture, S2 multiply, S3 shift + format
  // --------------------------------------------------------------------------
  logic [DW-1:0]        s1_ch0_q, s1_ch1_q;
  logic [GW:0]          s1_gain_q;
  logic signed [PW-1:0] p0_q, p1_q;
  logic signed [PW-1:0] w_a0, w_a1, w_g;
  logic signed [PW-1:0] w_prod0, w_prod1;
  logic [DW-1:0]        ch0_q, ch1_q;
  logic [DW-1:0]        data_q;
  logic                 sel_q;

  // Both operands sign/zero-extended to the full product width so the
  // truncated product is exact for every sample and gain 0..2**GW.
  assign w_a0    = $signed({{(GW + 2){s1_ch0_q[DW-1]}}, s1_ch0_q});
  assign w_a1    = $signed({{(GW + 2){s1_ch1_q[DW-1]}}, s1_ch1_q});
  assign w_g     = $signed({{(DW + 1){1'b0}}, s1_gain_q});
  assign w_prod0 = w_a0 * w_g;
  assign w_prod1 = w_a1 * w_g;

  // Only bits [GW +: DW] of the product survive the shift; taking that slice
  // of the two's complement product is the floor (toward -inf) divide.
  logic w_unused_prod;
  assign w_unused_prod = ^{p0_q[PW-1:GW+DW], p0_q[GW-1:0],
                           p1_q[PW-1:GW+DW], p1_q[GW-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ch0_q  <= '0;
      s1_ch1_q  <= '0;
      s1_gain_q <= '0;
      p0_q      <= '0;
      p1_q      <= '0;
      ch0_q     <= FMT_MASK;
      ch1_q     <= FMT_MASK;
      sel_q     <= 1'b0;
      data_q    <= FMT_MASK;
    end else begin
      // Gain is captured alongside the sample so it travels the pipe with it.
      s1_ch0_q  <= dac_ch0_i;
      s1_ch1_q  <= dac_ch1_i;
      s1_gain_q <= gain_q;
      p0_q      <= w_prod0;
      p1_q      <= w_prod1;
      ch0_q     <= p0_q[GW +: DW] ^ FMT_MASK;
      ch1_q     <= p1_q[GW +: DW] ^ FMT_MASK;
      sel_q     <= ~sel_q;
      // Next select is ~sel_q: load ch0 when it will read 0, ch1 otherwise.
      data_q    <= sel_q ? ch0_q : ch1_q;
    end
  end

  assign dac_ch0_o   = ch0_q;
  assign dac_ch1_o   = ch1_q;
  assign dac_data_o  = data_q;
  assign dac_sel_o   = sel_q;
  assign dac_on_o    = on_q;
  assign ramp_busy_o = busy_q;
  assign gain_o      = gain_q;

endmodule

`default_nettype wire

// File: doc/dac_output_stage.md
Name: dac_output_stage

Overview:
- Sits directly downstream of dac_mem_controller and drives the DAC pins.
- Takes the two 14-bit signed sample streams and applies a glitch-free soft-start/soft-stop gain ramp keyed on the DAC enable.
- Converts the result to the DAC's code format.
- Presents both parallel per-channel outputs and a single interleaved bus with channel select, for single-port dual DACs.

Parameters:
- DW, 14, sample width in bits for inputs and outputs.
- GW, 8, gain fraction bits; unity gain = 2**GW.
- RAMP_DIV, 64, clock cycles per gain step (>=1).
- OFFSET_BIN, 1, 1 = offset-binary output codes; 0 = two's complement passthrough.

Ports:
- clk  in  1  system clock, same domain as dac_mem_controller.
- rst_n  in  1  asynchronous active-low reset.
- dac_en_i  in  1  CSR enable; level-sensitive.
- dac_ch0_i  in  DW  channel 0 sample, two's complement.
- dac_ch1_i  in  DW  channel 1 sample, two's complement.
- dac_ch0_o  out  DW  channel 0 scaled and formatted code.
- dac_ch1_o  out  DW  channel 1 scaled and formatted code.
- dac_data_o  out  DW  interleaved code: ch0 when dac_sel_o=0, ch1 when dac_sel_o=1.
- dac_sel_o  out  1  interleave select; toggles every clk.
- dac_on_o  out  1  high only in state ON.
- ramp_busy_o  out  1  high in RAMP_UP or RAMP_DOWN.
- gain_o  out  GW+1  current gain (unsigned).

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous assert, synchronous deassert handled externally; all flops reset on its falling edge.
- Reset values:
  - State OFF, gain 0, divider 0, dac_sel_o 0, dac_on_o 0, ramp_busy_o 0.
  - Data outputs at midscale: 2**(DW-1) (14'h2000) if OFFSET_BIN, else 0.
  - Pipeline registers cleared to sample value 0.
- FSM states:
  - OFF: gain held at 0. Go to RAMP_UP when dac_en_i=1.
  - RAMP_UP: gain increments by 1 when the divider reaches RAMP_DIV-1 (divider then wraps to 0). Go to ON on the cycle gain becomes 2**GW. If dac_en_i=0, go to RAMP_DOWN keeping the current gain.
  - ON: gain held at 2**GW. Go to RAMP_DOWN when dac_en_i=0.
  - RAMP_DOWN: gain decrements by 1 per RAMP_DIV cycles. Go to OFF on the cycle gain becomes 0. If dac_en_i=1, go to RAMP_UP keeping the current gain.
  - The divider clears to 0 on every state entry.
  - A full ramp from OFF takes 2**GW * RAMP_DIV cycles from the first cycle dac_en_i is sampled high.
  - dac_en_i toggling every cycle must never make gain jump by more than 1 per step or leave the range 0..2**GW.
- Datapath (3 stages, both channels identical):
  - S1: register inputs.
  - S2: signed product = sample * signed({1'b0, gain}), width DW+GW+2. The gain used is the value registered in the same cycle S1 captured the sample.
  - S3: arithmetic shift right by GW (floor toward -inf). Result always fits in DW bits; no saturation needed. Format: OFFSET_BIN inverts the MSB.
  - Latency from dac_chX_i to dac_chX_o is 3 cycles.
  - Unity gain reproduces the input exactly; gain 0 yields midscale.
- Interleave:
  - dac_sel_o toggles every clk after reset.
  - dac_data_o registers dac_ch0_o when the next dac_sel_o is 0, else dac_ch1_o.
  - Latency from input to interleaved output is 4 cycles. Each channel is updated at clk/2.
- Reset mid-ramp: immediate return to OFF, midscale outputs, gain 0. No ramp-down is performed.
- Status flags and gain_o are registered and change in the same cycle as the state or gain register.

Test Plan:
- Reset check (GW=2, RAMP_DIV=4, OFFSET_BIN=1): hold rst_n=0 with inputs nonzero -> all data outputs 14'h2000, gain_o=0, dac_sel_o=0, flags 0.
- Ramp up: dac_ch0_i=14'h1000 constant, dac_en_i raised.
  - gain_o steps 1,2,3,4 every 4 cycles.
  - dac_ch0_o steps 14'h2400, 14'h2800, 14'h2C00, 14'h3000 (3 cycles after each gain change).
  - dac_on_o rises 16 cycles after dac_en_i is sampled high; ramp_busy_o is high for those 16 cycles.
- Negative floor: dac_ch1_i=-3 (14'h3FFD) at gain 1 -> dac_ch1_o=14'h1FFF (-1). At gain 4 -> 14'h1FFD.
- Reversal: drop dac_en_i when gain_o=2 during RAMP_UP -> next steps 1,0, then OFF and outputs 14'h2000. Re-raise at gain 1 during RAMP_DOWN -> RAMP_UP resumes 2,3,4.
- Interleave: ch0=14'h0005, ch1=14'h3FFB at unity -> dac_data_o alternates 14'h2005 (sel=0) and 14'h1FFB (sel=1), stable per phase.
- Async reset mid-ON: pulse rst_n low between clock edges -> outputs become 14'h2000 and state OFF immediately without waiting for clk. After release with dac_en_i=1, a fresh 16-cycle ramp occurs.
